// File: rtl/mem_port_master.sv
// Requester-side sequencer for a single-port async-read RAM: byte read, big-endian word read, byte write.
// Optional macro MEM_PORT_MASTER_ERR_EN adds o_rsp_err for the reserved op and wrapped word reads.
module mem_port_master #(
  parameter int AW = 15,
  parameter int DW = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_op,
  input  logic [AW-1:0]     i_req_addr,
  input  logic [DW-1:0]     i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [2*DW-1:0]   o_rsp_data,
  output logic [AW-1:0]     o_ram_address,
  output logic [DW-1:0]     o_ram_datain,
  output logic              o_ram_we,
  input  logic [DW-1:0]     i_ram_dataout
`ifdef MEM_PORT_MASTER_ERR_EN
  ,
  output logic              o_rsp_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_B0, S_B1, S_RSP} state_t;

  localparam logic [1:0] OP_RD8  = 2'b00;
  localparam logic [1:0] OP_RD16 = 2'b01;
  localparam logic [1:0] OP_WR8  = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  state_t            r_state;
  logic [1:0]        r_op;
  logic [2*DW-1:0]   r_rsp_data;
  logic [AW-1:0]     r_ram_address;
  logic [DW-1:0]     r_ram_datain;
  logic              r_ram_we;
  logic              w_accept;

  assign w_accept      = (r_state == S_IDLE) && i_req_valid;
  assign o_req_ready   = (r_state == S_IDLE);
  assign o_rsp_valid   = (r_state == S_RSP);
  assign o_rsp_data    = r_rsp_data;
  assign o_ram_address = r_ram_address;
  assign o_ram_datain  = r_ram_datain;
  assign o_ram_we      = r_ram_we;

  // The RAM address is loaded at the accept edge so it is already valid throughout B0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_op          <= OP_RD8;
      r_rsp_data    <= '0;
      r_ram_address <= '0;
      r_ram_datain  <= '0;
      r_ram_we      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_op          <= i_req_op;
            r_ram_address <= i_req_addr;
            if (i_req_op == OP_WR8) begin
              r_ram_datain <= i_req_wdata;
              r_ram_we     <= 1'b1;
            end
            r_state <= S_B0;
          end
        end
        S_B0: begin
          r_ram_we <= 1'b0;
          case (r_op)
            OP_RD8: begin
              r_rsp_data <= {{DW{1'b0}}, i_ram_dataout};
              r_state    <= S_RSP;
            end
            OP_RD16: begin
              r_rsp_data[2*DW-1:DW] <= i_ram_dataout;
              r_ram_address         <= r_ram_address + {{(AW-1){1'b0}}, 1'b1};
              r_state               <= S_B1;
            end
            OP_WR8: begin
              r_rsp_data <= '0;
              r_state    <= S_RSP;
            end
            OP_RSV: begin
              r_rsp_data <= '0;
              r_state    <= S_RSP;
            end
            default: r_state <= S_RSP;
          endcase
        end
        S_B1: begin
          r_rsp_data[DW-1:0] <= i_ram_dataout;
          r_state            <= S_RSP;
        end
        S_RSP: begin
          if (i_rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_PORT_MASTER_ERR_EN
  logic r_rsp_err;

  // A word read at the top address still completes; the flag only reports the wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_err <= 1'b0;
    end else if (w_accept) begin
      r_rsp_err <= 1'b0;
    end else if (r_state == S_B0) begin
      r_rsp_err <= (r_op == OP_RSV) || ((r_op == OP_RD16) && (&r_ram_address));
    end
  end

  assign o_rsp_err = r_rsp_err;
`else
  logic w_unused_accept;
  assign w_unused_accept = w_accept;
`endif

endmodule

// File: tb/tb_mem_port_master.sv
// Directed bench for mem_port_master with a behavioural 32Kx8 async-read RAM.
// Build with +define+MEM_PORT_MASTER_ERR_EN to also check rsp_err.
module tb_mem_port_master;

  logic        clk;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic [1:0]  reqOp;
  logic [14:0] reqAddr;
  logic [7:0]  reqWdata;
  logic        rspValid;
  logic        rspReady;
  logic [15:0] rspData;
  logic [14:0] ramAddress;
  logic [7:0]  ramDatain;
  logic        ramWe;
  logic [7:0]  ramDataout;
  logic        rspErr;

  logic [7:0]  mem [0:32767];
  logic        plEn;
  logic [14:0] plAddr;
  logic [7:0]  plData;

  int applied;
  int miscompares;

  mem_port_master #(.AW(15), .DW(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_req_valid   (reqValid),
    .o_req_ready   (reqReady),
    .i_req_op      (reqOp),
    .i_req_addr    (reqAddr),
    .i_req_wdata   (reqWdata),
    .o_rsp_valid   (rspValid),
    .i_rsp_ready   (rspReady),
    .o_rsp_data    (rspData),
    .o_ram_address (ramAddress),
    .o_ram_datain  (ramDatain),
    .o_ram_we      (ramWe),
    .i_ram_dataout (ramDataout)
`ifdef MEM_PORT_MASTER_ERR_EN
    ,
    .o_rsp_err     (rspErr)
`endif
  );

`ifndef MEM_PORT_MASTER_ERR_EN
  assign rspErr = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: combinational read, posedge write; bench preloads share the write port.
  assign ramDataout = mem[ramAddress];
  always @(posedge clk) begin
    if (ramWe) mem[ramAddress] <= ramDatain;
    if (plEn) mem[plAddr] <= plData;
  end

  typedef struct {
    logic [1:0]  op;
    logic [14:0] addr;
    logic [7:0]  wd;
    logic [15:0] expData;
    int          expLat;
    int          expWe;
    logic        expErr;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [14:0] a, input logic [7:0] d);
    @(negedge clk);
    plEn = 1'b1;
    plAddr = a;
    plData = d;
    @(negedge clk);
    plEn = 1'b0;
  endtask

  // Issues one request, follows it to the response, records what was seen, then consumes it.
  task automatic applyStimulus(input logic [1:0] op, input logic [14:0] addr, input logic [7:0] wd,
                               output logic [15:0] data, output int lat, output int weCnt,
                               output logic [14:0] a0, output logic [14:0] a1, output logic err,
                               output logic valid);
    @(negedge clk);
    reqOp = op;
    reqAddr = addr;
    reqWdata = wd;
    reqValid = 1'b1;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    lat = 1;
    weCnt = int'(ramWe);
    a0 = ramAddress;
    a1 = ramAddress;
    while (!rspValid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 2) a1 = ramAddress;
      weCnt += int'(ramWe);
    end
    valid = rspValid;
    data = rspData;
    err = rspErr;
    rspReady = 1'b1;
    @(posedge clk);
    #1;
    rspReady = 1'b0;
  endtask

  initial begin
    logic [15:0] data;
    int          lat;
    int          weCnt;
    logic [14:0] a0;
    logic [14:0] a1;
    logic [14:0] expA1;
    logic        err;
    logic        valid;

    applied = 0;
    miscompares = 0;
    rstN = 1'b0;
    reqValid = 1'b0;
    reqOp = 2'b00;
    reqAddr = '0;
    reqWdata = '0;
    rspReady = 1'b0;
    plEn = 1'b0;
    plAddr = '0;
    plData = '0;

    vecs[0] = '{2'b01, 15'h0002, 8'h00, 16'h0020, 3, 0, 1'b0};
    vecs[1] = '{2'b10, 15'h0022, 8'hA5, 16'h0000, 2, 1, 1'b0};
    vecs[2] = '{2'b00, 15'h0022, 8'h00, 16'h00A5, 2, 0, 1'b0};
    vecs[3] = '{2'b00, 15'h0020, 8'h00, 16'h0008, 2, 0, 1'b0};
    vecs[4] = '{2'b01, 15'h7FFF, 8'h00, 16'h1234, 3, 0, 1'b1};
    vecs[5] = '{2'b11, 15'h0010, 8'hFF, 16'h0000, 2, 0, 1'b1};
    vecs[6] = '{2'b00, 15'h0010, 8'h00, 16'h005A, 2, 0, 1'b0};
    vecs[7] = '{2'b01, 15'h0100, 8'h00, 16'hC37E, 3, 0, 1'b0};
    vecs[8] = '{2'b10, 15'h7FFF, 8'h99, 16'h0000, 2, 1, 1'b0};
    vecs[9] = '{2'b01, 15'h7FFE, 8'h00, 16'h1199, 3, 0, 1'b0};

    repeat (3) @(negedge clk);
    checkOutput("reset req_ready", 32'(reqReady), 32'h1);
    checkOutput("reset rsp_valid", 32'(rspValid), 32'h0);
    checkOutput("reset rsp_data", 32'(rspData), 32'h0);
    checkOutput("reset ram_we", 32'(ramWe), 32'h0);
    checkOutput("reset ram_address", 32'(ramAddress), 32'h0);
    checkOutput("reset ram_datain", 32'(ramDatain), 32'h0);
    rstN = 1'b1;

    preload(15'h0002, 8'h00);
    preload(15'h0003, 8'h20);
    preload(15'h0020, 8'h08);
    preload(15'h7FFF, 8'h12);
    preload(15'h0000, 8'h34);
    preload(15'h0010, 8'h5A);
    preload(15'h0100, 8'hC3);
    preload(15'h0101, 8'h7E);
    preload(15'h7FFE, 8'h11);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].wd, data, lat, weCnt, a0, a1, err, valid);
      checkOutput($sformatf("v%0d rsp_valid", i), 32'(valid), 32'h1);
      checkOutput($sformatf("v%0d rsp_data", i), 32'(data), 32'(vecs[i].expData));
      checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
      checkOutput($sformatf("v%0d we pulses", i), 32'(weCnt), 32'(vecs[i].expWe));
      checkOutput($sformatf("v%0d B0 address", i), 32'(a0), 32'(vecs[i].addr));
      if (vecs[i].op == 2'b01) begin
        expA1 = vecs[i].addr + 15'd1;
        checkOutput($sformatf("v%0d B1 address", i), 32'(a1), 32'(expA1));
      end
`ifdef MEM_PORT_MASTER_ERR_EN
      checkOutput($sformatf("v%0d rsp_err", i), 32'(err), 32'(vecs[i].expErr));
`endif
      checkOutput($sformatf("v%0d req_ready after", i), 32'(reqReady), 32'h1);
    end

    // Response held with rsp_ready low for five cycles.
    @(negedge clk);
    reqOp = 2'b00;
    reqAddr = 15'h0020;
    reqValid = 1'b1;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput($sformatf("hold%0d rsp_valid", c), 32'(rspValid), 32'h1);
      checkOutput($sformatf("hold%0d rsp_data", c), 32'(rspData), 32'h0008);
      checkOutput($sformatf("hold%0d req_ready", c), 32'(reqReady), 32'h0);
    end
    rspReady = 1'b1;
    @(posedge clk);
    #1;
    rspReady = 1'b0;
    checkOutput("hold release req_ready", 32'(reqReady), 32'h1);
    checkOutput("hold release rsp_valid", 32'(rspValid), 32'h0);

    // Asynchronous reset during B0 of a write.
    @(negedge clk);
    reqOp = 2'b10;
    reqAddr = 15'h0050;
    reqWdata = 8'h3C;
    reqValid = 1'b1;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    checkOutput("abort we in B0", 32'(ramWe), 32'h1);
    checkOutput("abort datain in B0", 32'(ramDatain), 32'h3C);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("abort we async", 32'(ramWe), 32'h0);
    checkOutput("abort rsp_valid async", 32'(rspValid), 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    checkOutput("abort req_ready", 32'(reqReady), 32'h1);
    checkOutput("abort rsp_data", 32'(rspData), 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("abort no response", 32'(rspValid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
